// File: rtl/sa_stream_driver.sv
// Host-side driver for the systolic-array core: feeds a job of operand beats,
// waits for the full result vector, then serialises it onto a result stream.
module sa_stream_driver #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned INWIDTH  = 8,
    parameter int unsigned OUTWIDTH = 32,
    parameter int unsigned KMAX     = 256,
    parameter int unsigned WAIT_MAX = 1024
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          start,
    input  logic [$clog2(KMAX+1)-1:0]     k_len,
    output logic                          busy,
    output logic                          done,
    output logic                          err,

    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [ROWS*INWIDTH-1:0]       op_a,
    input  logic [ROWS*INWIDTH-1:0]       op_w,

    output logic                          core_inpvalid,
    output logic [ROWS*INWIDTH-1:0]       core_ain,
    output logic [ROWS*INWIDTH-1:0]       core_win,
    input  logic [ROWS*OUTWIDTH-1:0]      core_rout,
    input  logic [ROWS-1:0]               core_rvalid,
    output logic                          core_outread,

    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [OUTWIDTH-1:0]           res_data,
    output logic [$clog2(ROWS)-1:0]       res_col,
    output logic                          res_last
);

    localparam int unsigned KW = $clog2(KMAX + 1);
    localparam int unsigned CW = $clog2(ROWS);
    localparam int unsigned WW = $clog2(WAIT_MAX + 1);

    localparam logic [KW-1:0] KLimit = KW'(KMAX);
    localparam logic [KW-1:0] KOne   = KW'(1);
    localparam logic [WW-1:0] WLast  = WW'(WAIT_MAX - 1);
    localparam logic [WW-1:0] WOne   = WW'(1);
    localparam logic [CW-1:0] CLast  = CW'(ROWS - 1);
    localparam logic [CW-1:0] COne   = CW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StWait,
        StCapt,
        StDrain,
        StFin
    } state_e;

    state_e              state_q;
    logic [KW-1:0]       k_lim_q;
    logic [KW-1:0]       k_cnt_q;
    logic [WW-1:0]       wait_cnt_q;
    logic [CW-1:0]       col_q;
    logic                err_q;
    logic [OUTWIDTH-1:0] rbuf_q [ROWS];
    logic                drain;

    assign drain        = (state_q == StDrain);
    assign op_ready     = (state_q == StFeed) && (k_cnt_q < k_lim_q);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFin);
    assign err          = err_q;
    assign core_outread = (state_q == StCapt);

    // Result outputs are forced to zero outside DRAIN so stale buffer data never leaks.
    assign res_valid = drain;
    assign res_data  = drain ? rbuf_q[col_q] : '0;
    assign res_col   = drain ? col_q : '0;
    assign res_last  = drain && (col_q == CLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            k_lim_q       <= '0;
            k_cnt_q       <= '0;
            wait_cnt_q    <= '0;
            col_q         <= '0;
            err_q         <= 1'b0;
            core_inpvalid <= 1'b0;
            core_ain      <= '0;
            core_win      <= '0;
            for (int i = 0; i < ROWS; i++) begin
                rbuf_q[i] <= '0;
            end
        end else begin
            core_inpvalid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        k_cnt_q <= '0;
                        if (k_len == '0) begin
                            state_q <= StFin;
                        end else begin
                            k_lim_q <= (k_len > KLimit) ? KLimit : k_len;
                            state_q <= StFeed;
                        end
                    end
                end
                StFeed: begin
                    if (op_valid && op_ready) begin
                        core_inpvalid <= 1'b1;
                        core_ain      <= op_a;
                        core_win      <= op_w;
                        k_cnt_q       <= k_cnt_q + KOne;
                        if (k_cnt_q + KOne == k_lim_q) begin
                            wait_cnt_q <= '0;
                            state_q    <= StWait;
                        end
                    end
                end
                StWait: begin
                    // A complete result vector wins over a timeout in the same cycle.
                    if (&core_rvalid) begin
                        state_q <= StCapt;
                    end else if (wait_cnt_q == WLast) begin
                        err_q   <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WOne;
                    end
                end
                StCapt: begin
                    for (int i = 0; i < ROWS; i++) begin
                        rbuf_q[i] <= core_rout[i*OUTWIDTH +: OUTWIDTH];
                    end
                    col_q   <= '0;
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (res_ready) begin
                        if (col_q == CLast) begin
                            state_q <= StFin;
                        end else begin
                            col_q <= col_q + COne;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_stream_driver.sv
// Randomised bench for sa_stream_driver: a job-level reference model checks every
// output each cycle; directed scenarios add literal expectations on top.
module tb_sa_stream_driver;

    localparam int ROWS     = 8;
    localparam int INWIDTH  = 8;
    localparam int OUTWIDTH = 32;
    localparam int KMAX     = 256;
    localparam int WAIT_MAX = 1024;
    localparam int KW       = $clog2(KMAX + 1);
    localparam int CW       = $clog2(ROWS);

    localparam int PI = 0, PFE = 1, PW = 2, PC = 3, PD = 4, PF = 5;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic [KW-1:0]            k_len = '0;
    logic                     busy, done, err;
    logic                     op_valid = 1'b0;
    logic                     op_ready;
    logic [ROWS*INWIDTH-1:0]  op_a = '0;
    logic [ROWS*INWIDTH-1:0]  op_w = '0;
    logic                     core_inpvalid;
    logic [ROWS*INWIDTH-1:0]  core_ain, core_win;
    logic [ROWS*OUTWIDTH-1:0] core_rout = '0;
    logic [ROWS-1:0]          core_rvalid = '0;
    logic                     core_outread;
    logic                     res_valid;
    logic                     res_ready = 1'b0;
    logic [OUTWIDTH-1:0]      res_data;
    logic [CW-1:0]            res_col;
    logic                     res_last;

    sa_stream_driver #(
        .ROWS(ROWS), .INWIDTH(INWIDTH), .OUTWIDTH(OUTWIDTH), .KMAX(KMAX), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .err(err), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_w(op_w),
        .core_inpvalid(core_inpvalid), .core_ain(core_ain), .core_win(core_win),
        .core_rout(core_rout), .core_rvalid(core_rvalid), .core_outread(core_outread),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_col(res_col), .res_last(res_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Stimulus knobs
    int op_pct = 100;
    int rdy_pct = 100;
    bit op_toggle = 1'b0;
    bit pat_mode = 1'b0;
    bit core_stuck = 1'b0;
    bit rout_pat = 1'b0;
    int job_k = 0;

    // Upstream operand source and downstream sink
    always @(posedge clk) begin
        #1;
        if (op_toggle) op_valid = ~op_valid;
        else op_valid = ($urandom_range(99) < op_pct);
        for (int i = 0; i < ROWS; i++) begin
            if (pat_mode) begin
                op_a[i*INWIDTH +: INWIDTH] = INWIDTH'(i + 1);
                op_w[i*INWIDTH +: INWIDTH] = INWIDTH'(8'h10 + i);
            end else begin
                op_a[i*INWIDTH +: INWIDTH] = INWIDTH'($urandom);
                op_w[i*INWIDTH +: INWIDTH] = INWIDTH'($urandom);
            end
        end
        res_ready = ($urandom_range(99) < rdy_pct);
    end

    // Core model: raises a full result vector a few cycles after the job's last operand
    int ccnt = 0;
    int cwait = -1;
    bit craised = 1'b0;
    logic [ROWS*OUTWIDTH-1:0] crout = '0;
    logic [ROWS-1:0] pv;

    always @(negedge clk) begin
        if (rst) begin
            ccnt = 0;
            cwait = -1;
            craised = 1'b0;
        end else begin
            if (core_outread || core_stuck) craised = 1'b0;
            if (cwait == 0) begin
                craised = 1'b1;
                cwait = -1;
                for (int i = 0; i < ROWS; i++)
                    crout[i*OUTWIDTH +: OUTWIDTH] = rout_pat ? OUTWIDTH'(i * 100)
                                                             : OUTWIDTH'($urandom);
            end else if (cwait > 0) begin
                cwait--;
            end
            if (core_inpvalid) begin
                ccnt++;
                if (ccnt == job_k) begin
                    ccnt = 0;
                    cwait = $urandom_range(3);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (core_stuck) begin
            core_rvalid = 8'h7F;
        end else if (craised) begin
            core_rvalid = '1;
        end else begin
            pv = ROWS'($urandom);
            pv[$urandom_range(ROWS - 1)] = 1'b0;
            core_rvalid = pv;
        end
        if (craised) core_rout = crout;
        else for (int i = 0; i < ROWS; i++) core_rout[i*OUTWIDTH +: OUTWIDTH] = $urandom;
    end

    // Reference model and per-cycle compare
    int m_ph = PI;
    int m_k = 0, m_acc = 0, m_wait = 0, m_start_cyc = 0;
    bit m_err = 1'b0, m_inp = 1'b0;
    logic [ROWS*INWIDTH-1:0] m_a = '0, m_w = '0;
    logic [OUTWIDTH-1:0] m_q[$];

    int inp_log[$];
    int done_log[$];
    int n_out = 0;
    logic [OUTWIDTH-1:0] rlog[$];
    int clog[$];
    bit llog[$];

    always @(negedge clk) begin
        cyc_n++;
        if (chk_en) begin
            chk("busy", busy, m_ph != PI);
            chk("done", done, m_ph == PF);
            chk("err", err, m_err);
            chk("op_ready", op_ready, (m_ph == PFE) && (m_acc < m_k));
            chk("core_inpvalid", core_inpvalid, m_inp);
            chk("core_ain", core_ain, m_a);
            chk("core_win", core_win, m_w);
            chk("core_outread", core_outread, m_ph == PC);
            chk("res_valid", res_valid, m_ph == PD);
            if (m_ph == PD) begin
                chk("res_data", res_data, m_q[0]);
                chk("res_col", res_col, ROWS - m_q.size());
                chk("res_last", res_last, m_q.size() == 1);
            end
        end
        if (!rst) begin
            if (core_inpvalid) inp_log.push_back(cyc_n);
            if (core_outread) n_out++;
            if (done) done_log.push_back(cyc_n);
            if (res_valid && res_ready) begin
                rlog.push_back(res_data);
                clog.push_back(int'(res_col));
                llog.push_back(res_last);
            end
        end
        if (rst) begin
            m_ph = PI; m_err = 1'b0; m_inp = 1'b0; m_a = '0; m_w = '0;
            m_k = 0; m_acc = 0; m_wait = 0;
            m_q.delete();
        end else begin
            m_inp = 1'b0;
            case (m_ph)
                PI: if (start) begin
                    m_start_cyc = cyc_n;
                    m_err = 1'b0;
                    if (k_len == 0) m_ph = PF;
                    else begin
                        m_k = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
                        m_acc = 0;
                        m_ph = PFE;
                    end
                end
                PFE: if (op_valid && m_acc < m_k) begin
                    m_inp = 1'b1; m_a = op_a; m_w = op_w;
                    m_acc++;
                    if (m_acc == m_k) begin m_ph = PW; m_wait = 0; end
                end
                PW: if (&core_rvalid) m_ph = PC;
                    else begin
                        m_wait++;
                        if (m_wait == WAIT_MAX) begin m_err = 1'b1; m_ph = PF; end
                    end
                PC: begin
                    m_q.delete();
                    for (int i = 0; i < ROWS; i++) m_q.push_back(core_rout[i*OUTWIDTH +: OUTWIDTH]);
                    m_ph = PD;
                end
                PD: if (res_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_ph = PF;
                end
                PF: m_ph = PI;
                default: m_ph = PI;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k);
        int t = 0;
        while (busy !== 1'b0 && t < 3000) begin step(); t++; end
        start = 1'b1;
        k_len = KW'(k);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t = 0;
        while (done !== 1'b1 && t < budget) begin step(); t++; end
        chk(tag, done, 1'b1);
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_op_ready"}, op_ready, 0);
        chk({tag, "_inpvalid"}, core_inpvalid, 0);
        chk({tag, "_outread"}, core_outread, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_last"}, res_last, 0);
        chk({tag, "_ain"}, core_ain, 0);
        chk({tag, "_win"}, core_win, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_col"}, res_col, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i0, o0, r0, d0, t;
        repeat (3) step();
        chk_en = 1'b1;
        rst = 1'b0;
        check_reset_vals("reset");

        // Single directed job
        pat_mode = 1'b1; rout_pat = 1'b1; op_pct = 100; rdy_pct = 100; job_k = 4;
        i0 = inp_log.size(); o0 = n_out; r0 = rlog.size(); d0 = done_log.size();
        start_job(4);
        wait_done(200, "t1_done");
        chk("t1_inp_pulses", inp_log.size() - i0, 4);
        chk("t1_inp_latency", inp_log[i0] - m_start_cyc, 2);
        chk("t1_inp_consecutive", inp_log[i0+3] - inp_log[i0], 3);
        chk("t1_ain_lane0", core_ain[7:0], 8'h01);
        chk("t1_win_lane7", core_win[63:56], 8'h17);
        chk("t1_outread", n_out - o0, 1);
        chk("t1_beats", rlog.size() - r0, ROWS);
        for (int i = 0; i < ROWS; i++) begin
            chk("t1_res_data", rlog[r0+i], i * 100);
            chk("t1_res_col", clog[r0+i], i);
            chk("t1_res_last", llog[r0+i], i == ROWS - 1);
        end
        chk("t1_done_pulses", done_log.size() - d0, 1);
        pat_mode = 1'b0; rout_pat = 1'b0;

        // Upstream bubbles
        op_toggle = 1'b1; job_k = 3;
        i0 = inp_log.size();
        start_job(3);
        wait_done(200, "t2_done");
        chk("t2_inp_pulses", inp_log.size() - i0, 3);
        op_toggle = 1'b0;

        // Random jobs under downstream backpressure
        rdy_pct = 50;
        for (int j = 0; j < 10; j++) begin
            op_pct = $urandom_range(30, 100);
            job_k = $urandom_range(1, 12);
            r0 = rlog.size(); i0 = inp_log.size();
            start_job(job_k);
            wait_done(500, "t3_done");
            chk("t3_inp_pulses", inp_log.size() - i0, job_k);
            chk("t3_beats", rlog.size() - r0, ROWS);
            for (int i = 0; i < ROWS; i++) chk("t3_col_order", clog[r0+i], i);
        end

        // Timeout with stuck partial valids
        rdy_pct = 100; op_pct = 100; core_stuck = 1'b1; job_k = 2;
        o0 = n_out; r0 = rlog.size();
        start_job(2);
        wait_done(WAIT_MAX + 100, "t4_done");
        chk("t4_err", err, 1);
        chk("t4_done_delay", done_log[$] - inp_log[$], WAIT_MAX);
        chk("t4_outread", n_out - o0, 0);
        chk("t4_beats", rlog.size() - r0, 0);
        repeat (3) step();
        chk("t4_err_sticky", err, 1);
        core_stuck = 1'b0; job_k = 1;
        start_job(1);
        chk("t4_err_cleared", err, 0);
        wait_done(200, "t4b_done");

        // Zero-length job
        job_k = 0; i0 = inp_log.size(); o0 = n_out;
        start_job(0);
        chk("t5_k0_done", done, 1);
        step(); step();
        chk("t5_k0_inp", inp_log.size() - i0, 0);
        chk("t5_k0_outread", n_out - o0, 0);

        // Start during FEED is ignored
        op_pct = 0; job_k = 5; i0 = inp_log.size();
        start_job(5);
        step(); step();
        start = 1'b1; k_len = KW'(1);
        step();
        start = 1'b0; op_pct = 100;
        wait_done(200, "t5_feed_done");
        chk("t5_feed_inp", inp_log.size() - i0, 5);

        // Reset in the middle of DRAIN
        job_k = 4; r0 = rlog.size();
        start_job(4);
        t = 0;
        while (rlog.size() < r0 + 3 && t < 200) begin step(); t++; end
        chk("t6_beats_before_rst", rlog.size() - r0, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("t6_rst");
        job_k = 3; r0 = rlog.size();
        start_job(3);
        wait_done(200, "t6_done");
        chk("t6_beats_after", rlog.size() - r0, ROWS);

        // Over-long k_len is clamped
        job_k = KMAX; i0 = inp_log.size();
        start_job(300);
        wait_done(KMAX + 200, "t7_done");
        chk("t7_clamp", inp_log.size() - i0, KMAX);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
